// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, keeps at most one word read
// in flight, and buffers returned instructions in an in-order queue for decode.
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic                     imem_req_o,
   output logic [31:0]              imem_addr_o,
   input  logic                     imem_rvalid_i,
   input  logic [31:0]              imem_rdata_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [31:0]              instr_o,
   output logic [31:0]              pc_o,
   output logic [31:0]              pc_plus4_o,
   input  logic                     branch_taken_i,
   input  logic [31:0]              branch_target_i,
   output logic [1:0]               dbg_state_o,
   output logic [$clog2(DEPTH):0]   dbg_count_o
);

   // Handshake: the head entry moves downstream on any cycle where
   // instr_valid_o and instr_ready_i are both high; valid never depends on ready.

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   state_t         state;
   logic [31:0]    fetch_pc;
   logic [31:0]    req_pc;
   logic [PW:0]    count;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [31:0]    instr_q [DEPTH];
   logic [31:0]    pc_q    [DEPTH];

   logic [31:0]    target;
   logic           push;
   logic           pop;
   logic           unused_target_bits;

   assign target             = {branch_target_i[31:2], 2'b00};
   assign unused_target_bits = ^branch_target_i[1:0];

   // A read is only issued with a free slot, so a push can never overflow.
   assign imem_req_o  = (state == S_FETCH) && (count < DEPTH_C) && !branch_taken_i && rst_i;
   assign imem_addr_o = fetch_pc;

   assign push = rst_i && (state == S_WAIT) && imem_rvalid_i && !branch_taken_i;
   assign pop  = instr_valid_o && instr_ready_i;

   assign instr_valid_o = rst_i && (count != '0);
   assign instr_o       = instr_valid_o ? instr_q[rd_ptr] : 32'h0;
   assign pc_o          = instr_valid_o ? pc_q[rd_ptr]    : 32'h0;
   assign pc_plus4_o    = pc_o + 32'd4;

   assign dbg_state_o = state;
   assign dbg_count_o = count;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= S_FETCH;
         fetch_pc <= RESET_PC;
         req_pc   <= 32'h0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (branch_taken_i) begin
                  fetch_pc <= target;
               end else if (imem_req_o) begin
                  state    <= S_WAIT;
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 32'd4;
               end
            end
            S_WAIT: begin
               if (branch_taken_i) begin
                  fetch_pc <= target;
                  state    <= imem_rvalid_i ? S_FETCH : S_DROP;
               end else if (imem_rvalid_i) begin
                  state <= S_FETCH;
               end
            end
            S_DROP: begin
               if (branch_taken_i) fetch_pc <= target;
               if (imem_rvalid_i)  state    <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase

         // A redirect flushes the queue; a pop in the same cycle still counts downstream.
         if (branch_taken_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + (PW+1)'(1);
               2'b01:   count <= count - (PW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[wr_ptr] <= imem_rdata_i;
         pc_q[wr_ptr]    <= req_pc;
      end
   end

endmodule
